// File: rtl/ones_pkg.sv
// Shared types and sizes for the ones-counter / ones-pattern-builder family.
// Holds the ASM state encoding and the count saturation helper.
package ones_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUILD = 2'd1,
        S_DONE  = 2'd2
    } ones_state_t;

    // Requests above WIDTH clamp to a full pattern
    function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] c);
        return (c > CW'(WIDTH)) ? CW'(WIDTH) : c;
    endfunction

endpackage

// File: rtl/ones_pattern_datapath.sv
// Datapath for the pattern builder: holds the thermometer pattern and the
// count of ones still to be shifted in.
module ones_pattern_datapath
    import ones_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_cnt,
    input  logic             shift_one,
    input  logic [CW-1:0]    count_in,
    output logic [WIDTH-1:0] pattern,
    output logic             remaining_zero
);

    logic [CW-1:0] remaining;

    // Load clears the pattern; each shift appends a one at the LSB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern   <= '0;
            remaining <= '0;
        end else if (load_cnt) begin
            pattern   <= '0;
            remaining <= sat_count(count_in);
        end else if (shift_one && (remaining != '0)) begin
            pattern   <= {pattern[WIDTH-2:0], 1'b1};
            remaining <= remaining - CW'(1);
        end
    end

    assign remaining_zero = (remaining == '0);

endmodule

// File: rtl/ones_pattern_builder.sv
// Builds a right-aligned thermometer code holding count_in ones, one bit per
// cycle, using a start/done handshake shared with the ones counter.
module ones_pattern_builder
    import ones_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CW-1:0]    count_in,
    output logic [WIDTH-1:0] pattern,
    output logic             busy,
    output logic             done
);

    ones_state_t state;
    ones_state_t state_next;
    logic        load_cnt;
    logic        shift_one;
    logic        remaining_zero;

    // State register; busy/done are registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == S_BUILD);
            done  <= (state_next == S_DONE);
        end
    end

    // Next-state logic; DONE waits for start to drop before re-arming
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start)          state_next = S_BUILD;
            S_BUILD: if (remaining_zero) state_next = S_DONE;
            S_DONE:  if (!start)         state_next = S_IDLE;
            default:                     state_next = S_IDLE;
        endcase
    end

    // Datapath controls
    always_comb begin
        load_cnt  = 1'b0;
        shift_one = 1'b0;
        case (state)
            S_IDLE:  load_cnt  = 1'b1;
            S_BUILD: shift_one = !remaining_zero;
            default: ;
        endcase
    end

    ones_pattern_datapath u_datapath (
        .clk            (clk),
        .reset          (reset),
        .load_cnt       (load_cnt),
        .shift_one      (shift_one),
        .count_in       (count_in),
        .pattern        (pattern),
        .remaining_zero (remaining_zero)
    );

endmodule

// File: tb/tb_ones_pattern_builder.sv
// Self-checking bench for ones_pattern_builder: directed scenarios plus
// randomized jobs checked against a cycle-indexed thermometer model.
module tb_ones_pattern_builder;
    import ones_pkg::*;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CW-1:0]    count_in;
    logic [WIDTH-1:0] pattern;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    ones_pattern_builder dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .count_in (count_in),
        .pattern  (pattern),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Model: a value made of n ones, right aligned
    function automatic logic [WIDTH-1:0] therm(input int n);
        return WIDTH'((1 << n) - 1);
    endfunction

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        count_in = '0;
        @(posedge clk); #1;
        total++; if (pattern !== '0) begin bad++; $display("FAIL reset_pattern got=%h want=00", pattern); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // One job from IDLE. drop_at: step index after which start drops and
    // count_in changes to new_cin (-1 = keep start high until DONE).
    task automatic run_job(input int cin, input int drop_at, input int new_cin);
        int n;
        n        = (cin > int'(WIDTH)) ? int'(WIDTH) : cin;
        count_in = CW'(cin);
        start    = 1'b1;
        for (int k = 0; k <= n + 1; k++) begin
            @(posedge clk); #1;
            total++;
            if (pattern !== therm((k < n) ? k : n)) begin
                bad++; $display("FAIL job_pattern cin=%0d k=%0d got=%h want=%h", cin, k, pattern, therm((k < n) ? k : n));
            end
            total++;
            if (busy !== (k <= n)) begin
                bad++; $display("FAIL job_busy cin=%0d k=%0d got=%b want=%b", cin, k, busy, (k <= n));
            end
            total++;
            if (done !== (k > n)) begin
                bad++; $display("FAIL job_done cin=%0d k=%0d got=%b want=%b", cin, k, done, (k > n));
            end
            if (k == drop_at) begin
                start    = 1'b0;
                count_in = CW'(new_cin);
            end
        end
        // What the ones counter would report on this result
        total++;
        if ($countones(pattern) !== n) begin
            bad++; $display("FAIL round_trip cin=%0d got=%0d want=%0d", cin, $countones(pattern), n);
        end
        if (start) begin
            for (int h = 0; h < 2; h++) begin
                @(posedge clk); #1;
                total++;
                if (pattern !== therm(n) || done !== 1'b1 || busy !== 1'b0) begin
                    bad++; $display("FAIL done_hold cin=%0d got=%h/%b/%b want=%h/1/0", cin, pattern, done, busy, therm(n));
                end
            end
            start = 1'b0;
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL back_to_idle cin=%0d done=%b busy=%b want 0/0", cin, done, busy);
        end
        @(posedge clk); #1;
        total++;
        if (pattern !== '0) begin
            bad++; $display("FAIL idle_clear cin=%0d got=%h want=00", cin, pattern);
        end
    endtask

    task automatic test_basic();
        test_reset();
        run_job(3, -1, 0);
    endtask

    task automatic test_zero();
        test_reset();
        run_job(0, 0, 0);
    endtask

    task automatic test_saturate();
        test_reset();
        run_job(13, -1, 0);
    endtask

    task automatic test_async_reset();
        test_reset();
        count_in = CW'(5);
        start    = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            @(posedge clk); #1;
        end
        total++; if (pattern !== 8'h03) begin bad++; $display("FAIL mid_pattern got=%h want=03", pattern); end
        #30 reset = 1'b1;
        #1;
        total++;
        if (pattern !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%h/%b/%b want=00/0/0", pattern, busy, done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        total++;
        if (pattern !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle got=%h/%b/%b want=00/0/0", pattern, busy, done);
        end
        run_job(2, -1, 0);
    endtask

    task automatic test_ignore_inputs();
        test_reset();
        run_job(4, 1, 7);
        run_job(7, -1, 0);
    endtask

    task automatic test_round_trip();
        test_reset();
        for (int n = 0; n <= int'(WIDTH); n++) run_job(n, -1, 0);
    endtask

    task automatic test_random();
        int cin;
        int drop;
        test_reset();
        for (int i = 0; i < 25; i++) begin
            cin  = int'($urandom_range(0, 15));
            drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : -1;
            run_job(cin, drop, int'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        count_in = '0;
        test_basic();
        test_zero();
        test_saturate();
        test_async_reset();
        test_ignore_inputs();
        test_round_trip();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
